// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock,
// fixed WIDTH-cycle latency, start/busy/done handshake, registered product.
module seq_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     partial;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               last_iter;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // DONE accepts a new start exactly like IDLE, giving back-to-back operation
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_iter  = (state == RUN) && (cnt == CW'(WIDTH-1));
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Partial sum keeps its carry so the shifted accumulator never loses a bit
  always_comb begin
    partial  = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    acc_next = {partial, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      ovf     <= 1'b0;
    end else if (accept) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        product <= acc_next;
        ovf     <= |acc_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected products are queued when an
// operation is issued and compared whenever the DUT pulses done.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  int          checks;
  int          errors;
  logic [32:0] exp_q[$];
  logic [32:0] exp_item;

  seq_multiplier #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [32:0] refModel(input logic [15:0] av,
                                           input logic [15:0] bv);
    logic [31:0] p;
    p = {16'd0, av} * {16'd0, bv};
    return {|p[31:16], p};
  endfunction

  // Drives a one-cycle start from a falling edge and queues the expected result
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    exp_q.push_back(refModel(av, bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("product", 64'(product), 64'(exp_item[31:0]));
        checkOutput("ovf", 64'(ovf), 64'(exp_item[32]));
        checkOutput("busy_in_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    int n;
    int pulses;
    logic [15:0] ra, rb;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_product", 64'(product), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);

    applyStimulus(16'd3, 16'd5);
    checkOutput("busy_running", 64'(busy), 64'd1);
    waitDone(n);
    checkOutput("latency_3x5", 64'(n), 64'd16);

    applyStimulus(16'hFFFF, 16'hFFFF);
    waitDone(n);
    applyStimulus(16'h0100, 16'h0100);
    waitDone(n);
    applyStimulus(16'h0000, 16'h1234);
    waitDone(n);
    checkOutput("latency_zero", 64'(n), 64'd16);
    applyStimulus(16'h1234, 16'h0001);
    waitDone(n);

    // A start pulse in the middle of RUN must not disturb the operation
    applyStimulus(16'd3, 16'd5);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        a     = 16'd99;
        b     = 16'd77;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput("latency_ignored_start", 64'(n), 64'd16);

    // Start held through DONE launches the next operation immediately
    applyStimulus(16'd11, 16'd13);
    a     = 16'd200;
    b     = 16'd300;
    start = 1'b1;
    exp_q.push_back(refModel(16'd200, 16'd300));
    waitDone(n);
    checkOutput("latency_b2b_first", 64'(n), 64'd16);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_spacing_b2b", 64'(n), 64'd17);

    // Reset in the middle of RUN aborts without a done pulse
    applyStimulus(16'd1000, 16'd1000);
    repeat (7) @(negedge clk);
    checkOutput("busy_before_abort", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_product", 64'(product), 64'd0);
    checkOutput("abort_ovf", 64'(ovf), 64'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("abort_no_done", 64'(pulses), 64'd0);
    applyStimulus(16'd7, 16'd9);
    waitDone(n);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 50 == 0) ra = 16'hFFFF;
      applyStimulus(ra, rb);
      waitDone(n);
      if (n != 16) checkOutput("latency_random", 64'(n), 64'd16);
    end

    // Back-to-back chain: next operands are presented while done is high
    @(negedge clk);
    a     = 16'($urandom);
    b     = 16'($urandom);
    start = 1'b1;
    exp_q.push_back(refModel(a, b));
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      waitDone(n);
      ra = 16'($urandom);
      rb = 16'($urandom);
      a  = ra;
      b  = rb;
      exp_q.push_back(refModel(ra, rb));
    end
    @(negedge clk);
    start = 1'b0;
    waitDone(n);
    @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
